// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 definitions.
//   - round constants K0..K3
//   - rotl: 32-bit rotate left
//   - f_t / k_t: round function and constant selected by round index
//   - state_e: controller states of sha1_unit_core
package sha1_pkg;

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  localparam logic [6:0] LAST_RND = 7'd79;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_t(input logic [6:0] t, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_t(input logic [6:0] t);
    if (t < 7'd20)      return K0;
    else if (t < 7'd40) return K1;
    else if (t < 7'd60) return K2;
    else                return K3;
  endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round.
//   a_i..e_i : working variables before the round
//   w_i      : schedule word W[t]
//   t_i      : round index 0..79
//   a_o..e_o : working variables after the round
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  t_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  assign a_o = rotl(a_i, 5) + f_t(t_i, b_i, c_i, d_i) + e_i + k_t(t_i) + w_i;
  assign b_o = a_i;
  assign c_o = rotl(b_i, 30);
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/sha1_unit_core.sv
// sha1_unit_core: iterative SHA-1 compression, one round per clock.
//   clk, reset            : clock, synchronous active-high reset
//   i_tvalid_in/o_tready_in : block input handshake (i_data_in = W[0..79], i_A..i_E = H0..H4)
//   o_tvalid_out/i_tready_out : result handshake (o_A..o_E = H0'..H4')
// Handshake at edge N, rounds on N+1..N+80, feed-forward sum registered at N+81,
// result held in DONE until accepted.
module sha1_unit_core
  import sha1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             o_tready_in,
  input  logic             i_tvalid_in,
  input  logic [79:0][31:0] i_data_in,
  input  logic [31:0]      i_A,
  input  logic [31:0]      i_B,
  input  logic [31:0]      i_C,
  input  logic [31:0]      i_D,
  input  logic [31:0]      i_E,
  input  logic             i_tready_out,
  output logic             o_tvalid_out,
  output logic [31:0]      o_A,
  output logic [31:0]      o_B,
  output logic [31:0]      o_C,
  output logic [31:0]      o_D,
  output logic [31:0]      o_E
);

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [79:0][31:0] w_q;
  logic [4:0][31:0]  h_q;                  // latched initial chaining value, [0]=A
  logic [4:0][31:0]  wk_q, wk_d;           // working a..e, [0]=a
  logic [4:0][31:0]  out_q, out_d;
  logic [4:0][31:0]  rnd;
  logic [31:0]       w_sel;
  logic              load;

  // cnt_q reaches 80 on the feed-forward cycle; keep the index in range there.
  assign w_sel = (cnt_q <= LAST_RND) ? w_q[cnt_q] : 32'h0;

  sha1_round u_round (
    .a_i (wk_q[0]), .b_i (wk_q[1]), .c_i (wk_q[2]), .d_i (wk_q[3]), .e_i (wk_q[4]),
    .w_i (w_sel),   .t_i (cnt_q),
    .a_o (rnd[0]),  .b_o (rnd[1]),  .c_o (rnd[2]),  .d_o (rnd[3]),  .e_o (rnd[4])
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    out_d   = out_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tvalid_in) begin
          load    = 1'b1;
          wk_d    = {i_E, i_D, i_C, i_B, i_A};
          cnt_d   = 7'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q > LAST_RND) begin
          // all 80 rounds done: register the feed-forward sum
          for (int i = 0; i < 5; i++) out_d[i] = h_q[i] + wk_q[i];
          state_d = DONE;
        end else begin
          wk_d  = rnd;
          cnt_d = cnt_q + 7'd1;
        end
      end
      DONE: begin
        if (i_tready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wk_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wk_q    <= wk_d;
      out_q   <= out_d;
    end
  end

  // Block storage needs no reset; it is only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      w_q <= i_data_in;
      h_q <= {i_E, i_D, i_C, i_B, i_A};
    end
  end

  assign o_tready_in  = (state_q == IDLE);
  assign o_tvalid_out = (state_q == DONE);
  assign o_A = out_q[0];
  assign o_B = out_q[1];
  assign o_C = out_q[2];
  assign o_D = out_q[3];
  assign o_E = out_q[4];

endmodule

// File: tb/tb_sha1_unit_core.sv
module tb_sha1_unit_core;

  logic             clk = 1'b0;
  logic             reset;
  logic             o_tready_in;
  logic             i_tvalid_in;
  logic [79:0][31:0] i_data_in;
  logic [31:0]      i_A, i_B, i_C, i_D, i_E;
  logic             i_tready_out;
  logic             o_tvalid_out;
  logic [31:0]      o_A, o_B, o_C, o_D, o_E;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha1_unit_core dut (
    .clk (clk), .reset (reset),
    .o_tready_in (o_tready_in), .i_tvalid_in (i_tvalid_in), .i_data_in (i_data_in),
    .i_A (i_A), .i_B (i_B), .i_C (i_C), .i_D (i_D), .i_E (i_E),
    .i_tready_out (i_tready_out), .o_tvalid_out (o_tvalid_out),
    .o_A (o_A), .o_B (o_B), .o_C (o_C), .o_D (o_D), .o_E (o_E)
  );

  // ---------------- reference model (standard SHA-1 compression) ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [79:0][31:0] expand(input logic [15:0][31:0] m);
    logic [79:0][31:0] w;
    for (int t = 0; t < 80; t++)
      if (t < 16) w[t] = m[t];
      else        w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    return w;
  endfunction

  function automatic logic [4:0][31:0] model(input logic [79:0][31:0] w,
                                             input logic [4:0][31:0] h);
    logic [31:0] v[5];
    logic [31:0] f, k, tmp;
    logic [4:0][31:0] r;
    for (int i = 0; i < 5; i++) v[i] = h[i];
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin f = (v[1] & v[2]) | (~v[1] & v[3]);                k = 32'h5A827999; end
        1:       begin f = v[1] ^ v[2] ^ v[3];                            k = 32'h6ED9EBA1; end
        2:       begin f = (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]); k = 32'h8F1BBCDC; end
        default: begin f = v[1] ^ v[2] ^ v[3];                            k = 32'hCA62C1D6; end
      endcase
      tmp  = rl(v[0], 5) + f + v[4] + k + w[t];
      v[4] = v[3]; v[3] = v[2]; v[2] = rl(v[1], 30); v[1] = v[0]; v[0] = tmp;
    end
    for (int i = 0; i < 5; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0][31:0] outs();
    return {o_E, o_D, o_C, o_B, o_A};
  endfunction

  task automatic chk_res(input string tag, input logic [4:0][31:0] exp);
    logic [4:0][31:0] o;
    o = outs();
    for (int i = 0; i < 5; i++) chk($sformatf("%s_H%0d", tag, i), o[i], exp[i]);
  endtask

  // Present a block; returns at the negedge just after the handshake edge.
  task automatic send(input logic [79:0][31:0] w, input logic [4:0][31:0] h, output int waited);
    waited = 0;
    while (!o_tready_in && waited < 300) begin @(negedge clk); waited++; end
    if (!o_tready_in) chk("send_timeout", 32'(o_tready_in), 32'd1);
    i_data_in = w;
    {i_E, i_D, i_C, i_B, i_A} = h;
    i_tvalid_in = 1'b1;
    @(negedge clk);
    i_tvalid_in = 1'b0;
  endtask

  // Wait for the result, check latency/value, hold it for 'hold' cycles, then accept.
  task automatic get_result(input string tag, input logic [4:0][31:0] exp, input int hold);
    int cyc;
    logic [4:0][31:0] held;
    cyc = 0;
    while (!o_tvalid_out && cyc < 200) begin @(negedge clk); cyc++; end
    chk({tag, "_lat"}, 32'(cyc), 32'd81);
    chk_res(tag, exp);
    held = outs();
    for (int i = 0; i < hold; i++) begin
      if (i == 5) begin
        // stray block offered while a result is pending: must be ignored
        i_data_in = '1; {i_E, i_D, i_C, i_B, i_A} = '1; i_tvalid_in = 1'b1;
      end else i_tvalid_in = 1'b0;
      @(negedge clk);
      chk({tag, "_hold_vld"}, 32'(o_tvalid_out), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(o_tready_in), 32'd0);
      chk({tag, "_hold_A"}, o_A, held[0]);
      chk({tag, "_hold_E"}, o_E, held[4]);
    end
    i_tvalid_in  = 1'b0;
    i_tready_out = 1'b1;
    @(negedge clk);
    chk({tag, "_xfer_vld"}, 32'(o_tvalid_out), 32'd0);
    chk({tag, "_xfer_rdy"}, 32'(o_tready_in), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0][31:0] m;
    logic [79:0][31:0] w, w2;
    logic [4:0][31:0]  h, h2, exp;
    int g;

    reset = 1'b1; i_tvalid_in = 1'b0; i_tready_out = 1'b1;
    i_data_in = '0; {i_E, i_D, i_C, i_B, i_A} = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tready_in", 32'(o_tready_in), 32'd1);
    chk("rst_tvalid_out", 32'(o_tvalid_out), 32'd0);
    chk_res("rst_out", '0);

    // "abc" known-answer vector
    m = '0; m[0] = 32'h61626380; m[15] = 32'h00000018;
    h = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
    w = expand(m);
    send(w, h, g);
    get_result("abc", {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36}, 0);

    // backpressure with a stray valid pulse during the hold window
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    for (int i = 0; i < 5; i++) h[i] = $urandom;
    w = expand(m);
    i_tready_out = 1'b0;
    send(w, h, g);
    get_result("bp", model(w, h), 20);
    repeat (3) @(negedge clk);
    chk("bp_stray_ignored", 32'(o_tready_in), 32'd1);

    // back-to-back identical blocks
    m = '0; m[0] = 32'd1; h = '0; w = expand(m); exp = model(w, h);
    for (int b = 0; b < 10; b++) begin
      send(w, h, g);
      if (b > 0) chk($sformatf("b2b%0d_nowait", b), 32'(g), 32'd0);
      get_result($sformatf("b2b%0d", b), exp, 0);
    end

    // reset in the middle of RUN (after rounds 0..39)
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    w = expand(m);
    send(w, h, g);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (o_tvalid_out) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      chk("abort_tready_in", 32'(o_tready_in), 32'd1);
    end
    for (int i = 0; i < 5; i++) h[i] = $urandom;
    send(w, h, g);
    get_result("after_abort", model(w, h), 0);

    // inputs change right after the handshake
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    for (int i = 0; i < 5; i++) h[i] = $urandom;
    w = expand(m); exp = model(w, h);
    send(w, h, g);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    w2 = expand(m); h2 = h; h2[0] = ~h[0];
    i_data_in = w2; i_A = h2[0];
    get_result("latched", exp, 0);

    // a few random blocks with random backpressure
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      for (int i = 0; i < 5; i++) h[i] = $urandom;
      w = expand(m);
      i_tready_out = 1'b0;
      send(w, h, g);
      get_result($sformatf("rnd%0d", b), model(w, h), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
